// File: rtl/dcache_sb_drain_pkg.sv
// Shared widths, address-field positions and FSM encodings for the store-buffer drain data cache.
package dcache_sb_drain_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int SB_WIDTH       = ADDR_WIDTH + DATA_WIDTH;
  localparam int NLINES         = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE;

  localparam int OFF_LSB   = 2;
  localparam int OFF_WIDTH = $clog2(WORDS_PER_LINE);
  localparam int IDX_LSB   = OFF_LSB + OFF_WIDTH;
  localparam int IDX_WIDTH = $clog2(NLINES);
  localparam int TAG_LSB   = IDX_LSB + IDX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } state_t;

  typedef enum logic {
    SRC_LOAD = 1'b0,
    SRC_SB   = 1'b1
  } src_t;

  function automatic logic [OFF_WIDTH-1:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_LSB +: OFF_WIDTH];
  endfunction

  function automatic logic [IDX_WIDTH-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_LSB +: IDX_WIDTH];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return a[TAG_LSB +: TAG_WIDTH];
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache, with combinational hit compares
// for the core address and the drain address plus a victim read port.
module dcache_tag_array
  import dcache_sb_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  output logic                  core_hit,
  output logic [DATA_WIDTH-1:0] core_word,
  input  logic [ADDR_WIDTH-1:0] sb_addr,
  output logic                  sb_hit,
  input  logic [IDX_WIDTH-1:0]  victim_idx,
  output logic                  victim_valid,
  output logic                  victim_dirty,
  output logic [TAG_WIDTH-1:0]  victim_tag,
  output logic [LINE_WIDTH-1:0] victim_line,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [LINE_WIDTH-1:0] fill_line,
  input  logic                  fill_dirty,
  input  logic                  clean_en,
  input  logic [IDX_WIDTH-1:0]  clean_idx
);

  logic [NLINES-1:0]     valid_q;
  logic [NLINES-1:0]     dirty_q;
  logic [TAG_WIDTH-1:0]  tag_q  [NLINES];
  logic [LINE_WIDTH-1:0] data_q [NLINES];

  logic [IDX_WIDTH-1:0] core_idx;
  logic [IDX_WIDTH-1:0] sb_idx;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic [IDX_WIDTH-1:0] fill_idx;
  logic                 unused_bits;

  assign core_idx = addr_idx(core_addr);
  assign sb_idx   = addr_idx(sb_addr);
  assign wr_idx   = addr_idx(wr_addr);
  assign fill_idx = addr_idx(fill_addr);

  assign core_hit  = valid_q[core_idx] && (tag_q[core_idx] == addr_tag(core_addr));
  assign core_word = data_q[core_idx][int'(addr_off(core_addr))*DATA_WIDTH +: DATA_WIDTH];
  assign sb_hit    = valid_q[sb_idx] && (tag_q[sb_idx] == addr_tag(sb_addr));

  assign victim_valid = valid_q[victim_idx];
  assign victim_dirty = dirty_q[victim_idx];
  assign victim_tag   = tag_q[victim_idx];
  assign victim_line  = data_q[victim_idx];

  assign unused_bits = ^{core_addr[OFF_LSB-1:0], sb_addr[OFF_LSB-1:0],
                         wr_addr[OFF_LSB-1:0], fill_addr[IDX_LSB-1:0]};

  // Only the status bits are reset; tag and data are meaningless while the line is invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= fill_dirty;
      end else if (wr_en) begin
        dirty_q[wr_idx] <= 1'b1;
      end
      if (clean_en) begin
        dirty_q[clean_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= addr_tag(fill_addr);
      data_q[fill_idx] <= fill_line;
    end else if (wr_en) begin
      data_q[wr_idx][int'(addr_off(wr_addr))*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_sb_drain.sv
// Direct-mapped write-back cache fed by store-buffer drains and core loads.
// Define DCACHE_STATS_EN to add hit/miss/write-back counters.
module dcache_sb_drain
  import dcache_sb_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  sb_valid,
  input  logic [SB_WIDTH-1:0]   sb_entry,
  output logic                  sb_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  cache_hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
`endif
);

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] miss_data;
  src_t                  miss_src;

  logic [ADDR_WIDTH-1:0] sb_addr;
  logic [DATA_WIDTH-1:0] sb_data;
  logic                  core_hit, sb_hit;
  logic [DATA_WIDTH-1:0] core_word;
  logic [IDX_WIDTH-1:0]  victim_idx;
  logic                  victim_valid, victim_dirty;
  logic [TAG_WIDTH-1:0]  victim_tag;
  logic [LINE_WIDTH-1:0] victim_line;
  logic                  load_miss, needs_wb, capture;
  logic                  wr_en, fill_en, fill_dirty, clean_en;
  logic [LINE_WIDTH-1:0] fill_line;

  assign sb_addr = sb_entry[SB_WIDTH-1 -: ADDR_WIDTH];
  assign sb_data = sb_entry[DATA_WIDTH-1:0];

  assign load_miss = (state == IDLE) && is_load && !core_hit;
  assign needs_wb  = victim_valid && victim_dirty;

  // In IDLE the victim is the line the pending miss would replace; afterwards it is the captured one.
  always_comb begin
    victim_idx = addr_idx(miss_addr);
    if (state == IDLE) begin
      victim_idx = load_miss ? addr_idx(in_addr) : addr_idx(sb_addr);
    end
  end

  assign cache_hit = (state == IDLE) && core_hit;
  assign out_data  = cache_hit ? core_word : '0;
  assign stall     = (state != IDLE);

  dcache_tag_array u_tags (
    .clk          (clk),
    .reset        (reset),
    .core_addr    (in_addr),
    .core_hit     (core_hit),
    .core_word    (core_word),
    .sb_addr      (sb_addr),
    .sb_hit       (sb_hit),
    .victim_idx   (victim_idx),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .wr_en        (wr_en),
    .wr_addr      (sb_addr),
    .wr_data      (sb_data),
    .fill_en      (fill_en),
    .fill_addr    (miss_addr),
    .fill_line    (fill_line),
    .fill_dirty   (fill_dirty),
    .clean_en     (clean_en),
    .clean_idx    (addr_idx(miss_addr))
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      miss_addr <= '0;
      miss_data <= '0;
      miss_src  <= SRC_LOAD;
    end else begin
      state <= next_state;
      if (capture) begin
        miss_addr <= load_miss ? in_addr : sb_addr;
        miss_src  <= load_miss ? SRC_LOAD : SRC_SB;
        miss_data <= sb_data;
      end
    end
  end

  // Load misses take priority over drains; a drain miss merges its word when the fill lands.
  always_comb begin
    next_state = state;
    sb_ack     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    fill_dirty = 1'b0;
    clean_en   = 1'b0;
    capture    = 1'b0;
    fill_line  = mem_rdata;
    case (state)
      IDLE: begin
        if (load_miss) begin
          capture    = 1'b1;
          next_state = needs_wb ? EVICT : FILL;
        end else if (sb_valid) begin
          if (sb_hit) begin
            wr_en  = 1'b1;
            sb_ack = 1'b1;
          end else begin
            capture    = 1'b1;
            next_state = needs_wb ? EVICT : FILL;
          end
        end
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag, addr_idx(miss_addr), {IDX_LSB{1'b0}}};
        mem_wdata = victim_line;
        if (mem_ready) begin
          clean_en   = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
        if (mem_ready) begin
          fill_en = 1'b1;
          if (miss_src == SRC_SB) begin
            fill_line[int'(addr_off(miss_addr))*DATA_WIDTH +: DATA_WIDTH] = miss_data;
            fill_dirty = 1'b1;
            sb_ack     = 1'b1;
          end
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if ((is_load || is_store) && cache_hit) hit_count <= hit_count + 32'd1;
      if ((state == IDLE) && (next_state != IDLE)) miss_count <= miss_count + 32'd1;
      if ((state == EVICT) && mem_ready) wb_count <= wb_count + 32'd1;
    end
  end
`else
  logic unused_store;
  assign unused_store = is_store;
`endif

endmodule

// File: tb/tb_dcache_sb_drain.sv
// Scoreboard bench for dcache_sb_drain: stimulus queues expected memory requests, drain acks
// and load data; a negedge monitor pops and compares them as the DUT presents each event.
module tb_dcache_sb_drain;
  import dcache_sb_drain_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  is_load;
  logic                  is_store;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  sb_valid;
  logic [SB_WIDTH-1:0]   sb_entry;
  logic                  sb_ack;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  cache_hit;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic        chk;
    logic [31:0] word2;
  } mem_exp_t;

  typedef struct packed {
    logic stall;
    logic ready;
  } ack_exp_t;

  mem_exp_t    mem_q[$];
  ack_exp_t    ack_q[$];
  logic [31:0] load_q[$];

  int errors = 0;
  int checks = 0;
  bit hold   = 0;

  dcache_sb_drain dut (
    .clk       (clk),
    .reset     (reset),
    .is_load   (is_load),
    .is_store  (is_store),
    .in_addr   (in_addr),
    .sb_valid  (sb_valid),
    .sb_entry  (sb_entry),
    .sb_ack    (sb_ack),
    .out_data  (out_data),
    .cache_hit (cache_hit),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  // Backing memory contents: word i of line L is {L[15:0],12'h0,i}, except line 0xA0 word 2.
  function automatic logic [LINE_WIDTH-1:0] lineOf(input logic [31:0] a);
    logic [LINE_WIDTH-1:0] l;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      l[i*32 +: 32] = {a[15:0], 12'h000, 4'(i)};
    end
    if (a == 32'h000000A0) l[95:64] = 32'h00001234;
    return l;
  endfunction

  // Memory model: completes each request two cycles after it is first seen, unless held.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !mem_ready && !hold && !reset) begin
        cnt++;
        if (cnt >= 2) begin
          mem_ready = 1'b1;
          mem_rdata = lineOf(mem_addr);
          cnt = 0;
        end
      end else begin
        mem_ready = 1'b0;
        if (!mem_req) cnt = 0;
      end
    end
  end

  // Monitor: compares each presented event against the oldest queued expectation.
  always @(negedge clk) begin
    mem_exp_t    me;
    ack_exp_t    ae;
    logic [31:0] le;
    if (!reset) begin
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) reportMissing("unexpected_mem_xfer");
        else begin
          me = mem_q.pop_front();
          checkOutput("mem_we", mem_we, me.we);
          checkOutput("mem_addr", mem_addr, me.addr);
          if (me.chk) checkOutput("mem_wdata_word2", mem_wdata[95:64], me.word2);
        end
      end
      if (sb_ack) begin
        if (ack_q.size() == 0) reportMissing("unexpected_sb_ack");
        else begin
          ae = ack_q.pop_front();
          checkOutput("ack_context", {stall, mem_ready}, {ae.stall, ae.ready});
        end
      end
      if (is_load && cache_hit && !stall) begin
        if (load_q.size() == 0) reportMissing("unexpected_load_hit");
        else begin
          le = load_q.pop_front();
          checkOutput("load_data", out_data, le);
        end
      end
    end
  end

  task automatic applyStimulus(input bit ld, input bit st, input logic [31:0] a,
                               input bit sv, input logic [31:0] sa, input logic [31:0] sd);
    is_load  = ld;
    is_store = st;
    in_addr  = a;
    sb_valid = sv;
    sb_entry = {sa, sd};
  endtask

  task automatic waitLoad();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cache_hit && !stall) break;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_timeout: got no hit expected hit within 50 cycles");
    end
    @(posedge clk);
    #1;
    is_load = 1'b0;
  endtask

  task automatic waitDrain(input bit immediate);
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb_ack) break;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got no sb_ack expected sb_ack within 50 cycles");
    end else if (immediate) begin
      checkOutput("drain_ack_latency", 32'(n), 0);
      checkOutput("drain_hit_no_req", mem_req, 0);
    end
    @(posedge clk);
    #1;
    sb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_sb_ack", sb_ack, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_cache_hit", cache_hit, 0);

    // Cold load miss on line 0xA0, then replay hit
    @(posedge clk); #1;
    mem_q.push_back('{we: 1'b0, addr: 32'hA0, chk: 1'b0, word2: 32'h0});
    load_q.push_back(32'h00001234);
    applyStimulus(1, 0, 32'hAA, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("cold_miss_hit", cache_hit, 0);
    @(negedge clk);
    checkOutput("fill_stall", stall, 1);
    checkOutput("fill_mem_req", mem_req, 1);
    checkOutput("fill_mem_we", mem_we, 0);
    checkOutput("fill_mem_addr", mem_addr, 32'hA0);
    waitLoad();

    // Drain hit into the resident line
    ack_q.push_back('{stall: 1'b0, ready: 1'b0});
    applyStimulus(0, 0, 32'h0, 1, 32'hA8, 32'h0000DDDD);
    waitDrain(1);
    load_q.push_back(32'h0000DDDD);
    applyStimulus(1, 0, 32'hA8, 0, 32'h0, 32'h0);
    waitLoad();

    // Drain miss to a cold line: fill then merge, ack on the ready cycle
    mem_q.push_back('{we: 1'b0, addr: 32'hB0, chk: 1'b0, word2: 32'h0});
    ack_q.push_back('{stall: 1'b1, ready: 1'b1});
    applyStimulus(0, 0, 32'h0, 1, 32'hBB, 32'h0000FFFF);
    waitDrain(0);
    load_q.push_back(32'h0000FFFF);
    applyStimulus(1, 0, 32'hB8, 0, 32'h0, 32'h0);
    waitLoad();

    // Conflict miss on the dirty 0xA0 line: write-back then fill
    mem_q.push_back('{we: 1'b1, addr: 32'hA0, chk: 1'b1, word2: 32'h0000DDDD});
    mem_q.push_back('{we: 1'b0, addr: 32'h10A0, chk: 1'b0, word2: 32'h0});
    load_q.push_back(32'h10A00000);
    applyStimulus(1, 0, 32'h10A0, 0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("evict_mem_we", mem_we, 1);
    checkOutput("evict_mem_addr", mem_addr, 32'hA0);
    waitLoad();

    // Load miss and drain together: the load is served first
    mem_q.push_back('{we: 1'b0, addr: 32'h0, chk: 1'b0, word2: 32'h0});
    load_q.push_back(32'h00000001);
    ack_q.push_back('{stall: 1'b0, ready: 1'b0});
    applyStimulus(1, 0, 32'h4, 1, 32'h10A4, 32'h0000CAFE);
    @(negedge clk);
    checkOutput("prio_no_ack", sb_ack, 0);
    fork
      waitLoad();
      waitDrain(0);
    join

    // Same-word load hit and drain hit: load sees the pre-write value
    load_q.push_back(32'h0000CAFE);
    ack_q.push_back('{stall: 1'b0, ready: 1'b0});
    applyStimulus(1, 0, 32'h10A4, 1, 32'h10A4, 32'h0000BEEF);
    fork
      waitLoad();
      waitDrain(1);
    join
    load_q.push_back(32'h0000BEEF);
    applyStimulus(1, 0, 32'h10A4, 0, 32'h0, 32'h0);
    waitLoad();

    // Store query only reports the hit
    applyStimulus(0, 1, 32'hB8, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("store_query_hit", cache_hit, 1);
    @(negedge clk);
    checkOutput("store_query_no_stall", stall, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0);

    // Reset while a fill is outstanding
    hold = 1'b1;
    applyStimulus(1, 0, 32'hC0, 0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_mem_req", mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    is_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_mem_req", mem_req, 0);
    checkOutput("post_reset_stall", stall, 0);
    @(posedge clk); #1;
    mem_q.push_back('{we: 1'b0, addr: 32'hA0, chk: 1'b0, word2: 32'h0});
    load_q.push_back(32'h00001234);
    applyStimulus(1, 0, 32'hA8, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post_reset_miss", cache_hit, 0);
    waitLoad();

    repeat (3) @(negedge clk);
    checkOutput("mem_q_drained", 32'(mem_q.size()), 0);
    checkOutput("ack_q_drained", 32'(ack_q.size()), 0);
    checkOutput("load_q_drained", 32'(load_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
